// File: rtl/led_wave_pwm_if.sv
// Configuration port of the LED wave generator: valid/ready request carrying
// the wave mode, phase step and channel-to-channel phase offset.
interface led_wave_pwm_if #(
   parameter int PWM_BITS = 8
);
   logic                valid;
   logic                ready;
   logic [1:0]          mode;
   logic [PWM_BITS:0]   step;
   logic [PWM_BITS:0]   offset;

   modport master (output valid, output mode, output step, output offset, input ready);
   modport slave  (input valid, input mode, input step, input offset, output ready);
endinterface

// File: rtl/led_wave_pwm.sv
// Multi-channel PWM wave generator: a triangle/sawtooth/square brightness pattern
// travels across the LED bank; config changes land only on PWM period boundaries.
//
// state  | meaning
// S_IDLE | ready for a new config request (ready=1)
// S_PEND | request held in shadow regs, waiting for the next period boundary
module led_wave_pwm #(
   parameter int                NUM_CH     = 8,
   parameter int                PWM_BITS   = 8,
   parameter int                RATE_BITS  = 17,
   parameter logic [PWM_BITS:0] DEF_STEP   = 1,
   parameter logic [PWM_BITS:0] DEF_OFFSET = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   led_wave_pwm_if.slave     cfg_if,
   output logic [NUM_CH-1:0] led_o
);

   typedef enum logic {S_IDLE, S_PEND} state_t;

   state_t                state_q, state_d;
   logic [PWM_BITS-1:0]   pwm_ctr_q, pwm_ctr_d;
   logic [RATE_BITS-1:0]  rate_ctr_q, rate_ctr_d;
   logic [PWM_BITS:0]     phase_q, phase_d;
   logic [1:0]            mode_q, sh_mode_q;
   logic [PWM_BITS:0]     step_q, sh_step_q;
   logic [PWM_BITS:0]     offset_q, sh_offset_q;
   logic [PWM_BITS-1:0]   level_q [NUM_CH];
   logic [PWM_BITS-1:0]   lvl_d [NUM_CH];
   logic [NUM_CH-1:0]     led_q, led_d;
   logic                  boundary, tick, capture, apply;
   logic [PWM_BITS:0]     ch_phase;

   assign boundary = en_i & (pwm_ctr_q == '1);
   assign tick     = &rate_ctr_q;

   always_comb begin
      pwm_ctr_d  = pwm_ctr_q;
      rate_ctr_d = rate_ctr_q;
      phase_d    = phase_q;
      if (en_i) begin
         pwm_ctr_d  = pwm_ctr_q + 1'b1;
         rate_ctr_d = rate_ctr_q + 1'b1;
         // step_q is still the old value in the cycle a new config is applied
         if (tick) phase_d = phase_q + step_q;
      end
   end

   always_comb begin
      ch_phase = phase_q;
      led_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         lvl_d[i] = '0;
         case (mode_q)
            2'd0: lvl_d[i] = ch_phase[PWM_BITS] ? ~ch_phase[PWM_BITS-1:0] : ch_phase[PWM_BITS-1:0];
            2'd1: lvl_d[i] = ch_phase[PWM_BITS-1:0];
            2'd2: lvl_d[i] = ch_phase[PWM_BITS] ? '1 : '0;
            default: lvl_d[i] = '0;
         endcase
         led_d[i] = en_i & (level_q[i] > pwm_ctr_q);
         ch_phase = ch_phase + offset_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      cfg_if.ready = 1'b0;
      capture      = 1'b0;
      apply        = 1'b0;
      case (state_q)
         S_IDLE: begin
            cfg_if.ready = 1'b1;
            if (cfg_if.valid) begin
               capture = 1'b1;
               state_d = S_PEND;
            end
         end
         S_PEND: begin
            if (boundary) begin
               apply   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         pwm_ctr_q   <= '0;
         rate_ctr_q  <= '0;
         phase_q     <= '0;
         mode_q      <= 2'd0;
         step_q      <= DEF_STEP;
         offset_q    <= DEF_OFFSET;
         sh_mode_q   <= 2'd0;
         sh_step_q   <= DEF_STEP;
         sh_offset_q <= DEF_OFFSET;
         led_q       <= '0;
         for (int i = 0; i < NUM_CH; i++) level_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         pwm_ctr_q  <= pwm_ctr_d;
         rate_ctr_q <= rate_ctr_d;
         phase_q    <= phase_d;
         led_q      <= led_d;
         if (boundary) begin
            for (int i = 0; i < NUM_CH; i++) level_q[i] <= lvl_d[i];
         end
         if (capture) begin
            sh_mode_q   <= cfg_if.mode;
            sh_step_q   <= cfg_if.step;
            sh_offset_q <= cfg_if.offset;
         end
         if (apply) begin
            mode_q   <= sh_mode_q;
            step_q   <= sh_step_q;
            offset_q <= sh_offset_q;
         end
      end
   end

   assign led_o = led_q;

endmodule

// File: tb/tb_led_wave_pwm.sv
// Directed plus randomized bench for led_wave_pwm against a cycle-level
// arithmetic model of the wave generator.
module tb_led_wave_pwm;
   localparam int NCH = 4;
   localparam int PB  = 4;
   localparam int RB  = 2;
   localparam int PERIOD = 1 << PB;
   localparam int PHMOD  = 1 << (PB + 1);
   localparam int RMOD   = 1 << RB;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en  = 1'b0;
   logic [NCH-1:0] led;

   led_wave_pwm_if #(.PWM_BITS(PB)) cfg_if ();

   led_wave_pwm #(
      .NUM_CH(NCH), .PWM_BITS(PB), .RATE_BITS(RB),
      .DEF_STEP(5'd1), .DEF_OFFSET(5'd8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_if(cfg_if), .led_o(led)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int m_pwm, m_rate, m_phase, m_mode, m_step, m_off;
   int s_mode, s_step, s_off;
   int m_lvl [NCH];
   bit m_pend;
   int m_led;

   function automatic int wave_level(int ph, int md);
      int hi, lo;
      hi = ph / PERIOD;
      lo = ph % PERIOD;
      case (md)
         0: return hi ? (PERIOD - 1 - lo) : lo;
         1: return lo;
         2: return hi ? (PERIOD - 1) : 0;
         default: return 0;
      endcase
   endfunction

   task automatic model_update();
      bit bnd;
      int nled;
      if (rst) begin
         m_pwm = 0; m_rate = 0; m_phase = 0;
         m_mode = 0; m_step = 1; m_off = 8;
         m_pend = 0; m_led = 0;
         for (int i = 0; i < NCH; i++) m_lvl[i] = 0;
      end else begin
         bnd  = en && (m_pwm == PERIOD - 1);
         nled = 0;
         for (int i = 0; i < NCH; i++)
            if (en && (m_lvl[i] > m_pwm)) nled |= (1 << i);
         if (bnd)
            for (int i = 0; i < NCH; i++)
               m_lvl[i] = wave_level((m_phase + i * m_off) % PHMOD, m_mode);
         if (en) begin
            if (m_rate == RMOD - 1) m_phase = (m_phase + m_step) % PHMOD;
            m_pwm  = (m_pwm + 1) % PERIOD;
            m_rate = (m_rate + 1) % RMOD;
         end
         if (!m_pend) begin
            if (cfg_if.valid) begin
               s_mode = int'(cfg_if.mode);
               s_step = int'(cfg_if.step);
               s_off  = int'(cfg_if.offset);
               m_pend = 1;
            end
         end else if (bnd) begin
            m_mode = s_mode; m_step = s_step; m_off = s_off;
            m_pend = 0;
         end
         m_led = nled;
      end
   endtask

   task automatic check(string tag, int obs, int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check("led", int'(led), m_led);
      check("cfg_ready", int'(cfg_if.ready), m_pend ? 0 : 1);
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic send_cfg(int md, int st, int of);
      cfg_if.valid  = 1'b1;
      cfg_if.mode   = 2'(md);
      cfg_if.step   = 5'(st);
      cfg_if.offset = 5'(of);
      tick();
      cfg_if.valid  = 1'b0;
   endtask

   initial begin
      cfg_if.valid  = 1'b0;
      cfg_if.mode   = 2'd0;
      cfg_if.step   = 5'd0;
      cfg_if.offset = 5'd0;

      // reset, then free-run with default triangle settings
      run(2);
      rst = 1'b0;
      en  = 1'b1;
      run(64);

      // triangle with a step that drives phase across the fold point
      send_cfg(0, 5, 3);
      run(120);

      // square, offset 16, requested mid-period
      run(5);
      send_cfg(2, 1, 16);
      run(40);

      // request landing exactly on a boundary cycle
      for (int k = 0; k < PERIOD && m_pwm != PERIOD - 1; k++) tick();
      send_cfg(1, 3, 4);
      run(40);

      // pause mid-period
      run(6);
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(40);

      // reset while a request is pending
      run(3);
      send_cfg(2, 7, 16);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(48);

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         en            = ($urandom_range(0, 9) != 0);
         rst           = ($urandom_range(0, 399) == 0);
         cfg_if.valid  = ($urandom_range(0, 5) == 0);
         cfg_if.mode   = 2'($urandom_range(0, 3));
         cfg_if.step   = 5'($urandom_range(0, 31));
         cfg_if.offset = 5'($urandom_range(0, 31));
         tick();
      end
      rst = 1'b0;
      cfg_if.valid = 1'b0;
      en = 1'b1;
      run(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
